// File: rtl/half_clk_pkg.sv
// Shared constants and helpers for the registered clock divider.
package half_clk_pkg;

  localparam int unsigned MIN_DIV = 2;

  // Counter width for a given ratio; never narrower than one bit.
  function automatic int unsigned div_cw(input int unsigned div);
    int unsigned w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/half_clk_div_if.sv
// Observation bundle for the divider: exposes the phase counter to monitors.
interface half_clk_div_if
  import half_clk_pkg::*;
#(
  parameter int unsigned DIV = 2
);
  localparam int unsigned CW = div_cw(DIV);

  logic [CW-1:0] cnt;

  modport master (output cnt);
  modport slave  (input  cnt);
endinterface

// File: rtl/half_clk_div_mod_counter.sv
// Modulo-MOD up counter with synchronous active-high reset.
module mod_counter
  import half_clk_pkg::*;
#(
  parameter  int unsigned MOD = 2,
  localparam int unsigned CW  = div_cw(MOD)
) (
  input  logic          clk_in,
  input  logic          reset,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;
  logic          w_at_max;

  assign w_at_max = (r_cnt == CW'(MOD - 1));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_at_max) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/half_clk_div.sv
// Registered clock divider: clk_out period is DIV clk_in periods, driven from a flop.
module half_clk_div
  import half_clk_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic            clk_in,
  input  logic            reset,
  output logic            clk_out,
  half_clk_div_if.master  mon
);

  localparam int unsigned CW     = div_cw(DIV);
  // High phase is the longer one for odd ratios: ceil(DIV/2) cycles high.
  localparam int unsigned HI_LEN = (DIV + 1) / 2;

  if (DIV < MIN_DIV) begin : g_bad_div
    $error("half_clk_div: DIV must be >= 2");
  end

  logic [CW-1:0] w_cnt;
  logic          w_toggle;
  logic          r_clk_out;

  mod_counter #(
    .MOD (DIV)
  ) u_cnt (
    .clk_in (clk_in),
    .reset  (reset),
    .o_cnt  (w_cnt)
  );

  assign w_toggle = (w_cnt == '0) || (w_cnt == CW'(HI_LEN));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_clk_out <= 1'b0;
    end else if (w_toggle) begin
      r_clk_out <= ~r_clk_out;
    end
  end

  assign clk_out = r_clk_out;
  assign mon.cnt = w_cnt;

endmodule

// File: tb/tb_half_clk_div.sv
// Scoreboard bench for half_clk_div at DIV = 2, 3 and 4 sharing one clk_in.
module tb_half_clk_div;

  localparam int N_EDGES = 40;
  localparam int N_DUT   = 3;

  typedef struct {
    int   idx;
    int   edge_n;
    logic exp_out;
    int   exp_cnt;
  } exp_t;

  logic       clk_in = 1'b0;
  logic [2:0] rst;
  logic [2:0] w_out;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb[$];

  int   k       [N_DUT];
  logic snap    [N_DUT];
  logic run_val [N_DUT];
  int   run_len [N_DUT];
  bit   run_ok  [N_DUT];

  always #50 clk_in = ~clk_in;

  half_clk_div_if #(.DIV(2)) if2 ();
  half_clk_div_if #(.DIV(3)) if3 ();
  half_clk_div_if #(.DIV(4)) if4 ();

  half_clk_div #(.DIV(2)) u_div2 (.clk_in(clk_in), .reset(rst[0]), .clk_out(w_out[0]), .mon(if2));
  half_clk_div #(.DIV(3)) u_div3 (.clk_in(clk_in), .reset(rst[1]), .clk_out(w_out[1]), .mon(if3));
  half_clk_div #(.DIV(4)) u_div4 (.clk_in(clk_in), .reset(rst[2]), .clk_out(w_out[2]), .mon(if4));

  function automatic int div_of(input int i);
    return i + 2;
  endfunction

  function automatic logic [31:0] cnt_of(input int i);
    case (i)
      0:       return 32'(if2.cnt);
      1:       return 32'(if3.cnt);
      default: return 32'(if4.cnt);
    endcase
  endfunction

  // Reset schedule per DUT and edge: initial reset, held reset, and mid-period pulses.
  function automatic logic rst_at(input int i, input int n);
    case (i)
      0:       return (n == 0) || (n >= 11 && n <= 13) || (n == 17);
      1:       return (n == 0) || (n == 22);
      default: return (n == 0) || (n >= 20 && n <= 21);
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   d;
    rst = '1;
    for (int i = 0; i < N_DUT; i++) begin
      k[i] = 0; run_ok[i] = 1'b0; run_len[i] = 0; run_val[i] = 1'b0;
    end

    for (int n = 0; n < N_EDGES; n++) begin
      // Drive resets for the coming edge and push what the reference predicts.
      for (int i = 0; i < N_DUT; i++) begin
        d = div_of(i);
        rst[i] = rst_at(i, n);
        e.idx = i;
        e.edge_n = n;
        if (rst[i]) begin
          k[i] = 0;
          e.exp_out = 1'b0;
          e.exp_cnt = 0;
        end else begin
          k[i]++;
          e.exp_out = (((k[i] - 1) % d) < ((d + 1) / 2));
          e.exp_cnt = k[i] % d;
        end
        sb.push_back(e);
      end

      @(posedge clk_in);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        d = div_of(e.idx);
        check_val($sformatf("out div%0d edge%0d", d, e.edge_n), 32'(w_out[e.idx]), 32'(e.exp_out));
        check_val($sformatf("cnt div%0d edge%0d", d, e.edge_n), cnt_of(e.idx), 32'(e.exp_cnt));
        snap[e.idx] = w_out[e.idx];

        if (rst[e.idx]) begin
          run_ok[e.idx] = 1'b0;
        end else if (k[e.idx] == 1) begin
          run_val[e.idx] = w_out[e.idx];
          run_len[e.idx] = 1;
          run_ok[e.idx]  = 1'b1;
        end else if (w_out[e.idx] === run_val[e.idx]) begin
          run_len[e.idx]++;
        end else begin
          if (run_ok[e.idx])
            check_val($sformatf("runlen div%0d edge%0d lvl%0b", d, e.edge_n, run_val[e.idx]),
                      32'(run_len[e.idx]), run_val[e.idx] ? 32'((d + 1) / 2) : 32'(d / 2));
          run_val[e.idx] = w_out[e.idx];
          run_len[e.idx] = 1;
        end
      end

      // clk_out must hold between rising edges.
      @(negedge clk_in);
      for (int i = 0; i < N_DUT; i++)
        check_val($sformatf("stable div%0d edge%0d", div_of(i), n), 32'(w_out[i]), 32'(snap[i]));
      #20;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
